imem_boot_loader: RTL and testbench

//   Boot-time program loader placed directly upstream of the processor's instruction memory.

---
 rtl/imem_boot_loader_if.sv | 33 +++
 rtl/imem_boot_loader.sv | 150 +++++++++++++++
 tb/tb_imem_boot_loader.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_boot_loader_if.sv
// Byte-stream and IMEM write-port bundle for imem_boot_loader.
//
// Signals:
//   in_valid    stream -> loader   a byte is presented on in_data
//   in_data     stream -> loader   stream byte, most significant byte of a word first
//   in_ready    loader -> stream   loader accepts a byte this cycle
//   imem_we     loader -> IMEM     one-cycle write strobe per assembled word
//   imem_addr   loader -> IMEM     word address of the write
//   imem_wdata  loader -> IMEM     assembled 32-bit instruction word
//
// Modports:
//   slave   the loader's view (consumes the stream, drives the IMEM port)
//   master  the environment's view (drives the stream, observes the IMEM port)
interface imem_boot_loader_if #(
  parameter int ADDR_W = 4
) ();
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport slave (
    input  in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata
  );

  modport master (
    output in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_boot_loader.sv
// Boot-time program loader in front of the instruction memory.
// Packs a byte stream big-endian into 32-bit words, writes each word to IMEM,
// and holds the core in reset until a word with opcode 6'b111111 (EXIT) is
// written. Filling the last IMEM slot without an EXIT word is a load error.
//
// Optional feature macro: LOADER_CHECKSUM_EN
//   When defined, one extra byte after the EXIT word must equal the XOR of all
//   program bytes; a mismatch ends in the error state.
//
// Ports:
//   clk          clock, rising edge
//   resetn       synchronous, active-low reset
//   start        one-cycle pulse that begins a load (honoured in IDLE, DONE, ERR)
//   bus          imem_boot_loader_if.slave: byte stream in, IMEM write port out
//   word_count   words written during the current load
//   core_resetn  active-low reset to the processor, released only in DONE
//   load_done    level, load completed successfully
//   load_err     level, load failed
module imem_boot_loader #(
  parameter int IMEM_DEPTH = 16,
  parameter int ADDR_W     = $clog2(IMEM_DEPTH)
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  imem_boot_loader_if.slave    bus,
  output logic [ADDR_W:0]      word_count,
  output logic                 core_resetn,
  output logic                 load_done,
  output logic                 load_err
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMEM_DEPTH - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   WC_ONE    = (ADDR_W + 1)'(1);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_RECV, S_WRITE, S_DONE, S_ERR, S_CSUM
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_RECV, S_WRITE, S_DONE, S_ERR
  } state_t;
`endif

  state_t            state, state_nxt;
  logic [1:0]        byte_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              accept;
  logic              restart;
  logic              is_exit;
  logic              at_last;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        csum_q;
`endif

  always_comb begin
    accept  = (state == S_RECV) && bus.in_valid;
    restart = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));
    is_exit = (wdata_q[31:26] == 6'b111111);
    at_last = (addr_q == LAST_ADDR);
  end

  always_ff @(posedge clk) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RECV;
      S_RECV:  if (accept && (byte_cnt == 2'd3)) state_nxt = S_WRITE;
      // EXIT takes priority over the full-memory check, so an EXIT word in
      // the last slot is still a successful load.
      S_WRITE: begin
        if (is_exit) begin
`ifdef LOADER_CHECKSUM_EN
          state_nxt = S_CSUM;
`else
          state_nxt = S_DONE;
`endif
        end else if (at_last) begin
          state_nxt = S_ERR;
        end else begin
          state_nxt = S_RECV;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CSUM:  if (bus.in_valid) state_nxt = (bus.in_data == csum_q) ? S_DONE : S_ERR;
`endif
      S_DONE:  if (start) state_nxt = S_RECV;
      S_ERR:   if (start) state_nxt = S_RECV;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath registers. A restart clears the counters; an abort by reset
  // drops any partially assembled word because WRITE is never reached.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      byte_cnt   <= 2'd0;
      addr_q     <= '0;
      wdata_q    <= 32'd0;
      word_count <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum_q     <= 8'd0;
`endif
    end else begin
      if (restart) begin
        byte_cnt   <= 2'd0;
        addr_q     <= '0;
        word_count <= '0;
`ifdef LOADER_CHECKSUM_EN
        csum_q     <= 8'd0;
`endif
      end
      if (accept) begin
        wdata_q  <= {wdata_q[23:0], bus.in_data};
        byte_cnt <= byte_cnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
        csum_q   <= csum_q ^ bus.in_data;
`endif
      end
      if (state == S_WRITE) begin
        word_count <= word_count + WC_ONE;
        byte_cnt   <= 2'd0;
        // Address never wraps: it stays put on EXIT or on the last slot.
        if (!is_exit && !at_last) addr_q <= addr_q + ADDR_ONE;
      end
    end
  end

  // Moore outputs decoded from the registered state.
  always_comb begin
    bus.in_ready   = (state == S_RECV);
`ifdef LOADER_CHECKSUM_EN
    if (state == S_CSUM) bus.in_ready = 1'b1;
`endif
    bus.imem_we    = (state == S_WRITE);
    bus.imem_addr  = addr_q;
    bus.imem_wdata = wdata_q;
    core_resetn    = (state == S_DONE);
    load_done      = (state == S_DONE);
    load_err       = (state == S_ERR);
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed testbench for imem_boot_loader: drives byte streams through the
// interface, logs every IMEM write, and compares against hand-computed words.
module tb_imem_boot_loader;

  logic       clk;
  logic       resetn;
  logic       start;
  logic [4:0] word_count;
  logic       core_resetn;
  logic       load_done;
  logic       load_err;

  int checks = 0;
  int errors = 0;

  logic [3:0]  wa[$];
  logic [31:0] wd[$];
  logic [31:0] exp_w[$];

  imem_boot_loader_if #(.ADDR_W(4)) bif ();

  imem_boot_loader #(.IMEM_DEPTH(16), .ADDR_W(4)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .start       (start),
    .bus         (bif),
    .word_count  (word_count),
    .core_resetn (core_resetn),
    .load_done   (load_done),
    .load_err    (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write logger: imem_we is a full-cycle Moore strobe, so each write is seen
  // at exactly one falling edge.
  always @(negedge clk) begin
    if (bif.imem_we === 1'b1) begin
      wa.push_back(bif.imem_addr);
      wd.push_back(bif.imem_wdata);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    bif.in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    bif.in_valid = 1'b1;
    bif.in_data  = b;
    n = 0;
    while (bif.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (bif.in_ready !== 1'b1) check("ready_timeout", {63'd0, bif.in_ready}, 64'd1);
    @(negedge clk);
    bif.in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int g);
    for (int k = 0; k < 4; k++) begin
      send_byte(w[31-8*k -: 8], (g == 0) ? 0 : ((k + g) % 4));
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end();
    int n;
    n = 0;
    while (!(load_done === 1'b1 || load_err === 1'b1) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!(load_done === 1'b1 || load_err === 1'b1)) check("end_timeout", 64'd0, 64'd1);
  endtask

  task automatic check_log();
    check("we_count", wa.size(), exp_w.size());
    for (int i = 0; i < exp_w.size() && i < wa.size(); i++) begin
      check($sformatf("addr[%0d]", i), wa[i], i);
      check($sformatf("data[%0d]", i), wd[i], exp_w[i]);
    end
  endtask

  task automatic clear_log();
    wa.delete();
    wd.delete();
    exp_w.delete();
  endtask

  // Checksum byte required after an EXIT word when the feature is built in.
  task automatic send_csum(input logic [7:0] c);
`ifdef LOADER_CHECKSUM_EN
    wait_csum: begin
      @(negedge clk);
      send_byte(c, 0);
    end
`else
    check("no_csum_state", {63'd0, bif.in_ready}, 64'd0);
    if (c == 8'hFF) @(negedge clk);
`endif
  endtask

  initial begin
    resetn       = 1'b0;
    start        = 1'b0;
    bif.in_valid = 1'b0;
    bif.in_data  = 8'h00;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_ready", {63'd0, bif.in_ready}, 64'd0);
    check("rst_we", {63'd0, bif.imem_we}, 64'd0);
    check("rst_addr", bif.imem_addr, 64'd0);
    check("rst_wdata", bif.imem_wdata, 64'd0);
    check("rst_wc", word_count, 64'd0);
    check("rst_core", {63'd0, core_resetn}, 64'd0);
    check("rst_done", {63'd0, load_done}, 64'd0);
    check("rst_err", {63'd0, load_err}, 64'd0);
    resetn = 1'b1;
    @(negedge clk);
    check("idle_ready", {63'd0, bif.in_ready}, 64'd0);

    // Basic three-word load, back-to-back bytes
    clear_log();
    exp_w = '{32'h9000000A, 32'h90010004, 32'hFC000000};
    pulse_start();
    check("recv_ready", {63'd0, bif.in_ready}, 64'd1);
    send_word(32'h9000000A, 0);
    check("lat_we", {63'd0, bif.imem_we}, 64'd1);
    check("lat_wdata", bif.imem_wdata, 64'h9000000A);
    check("write_ready", {63'd0, bif.in_ready}, 64'd0);
    send_word(32'h90010004, 0);
    send_word(32'hFC000000, 0);
    check("exit_we", {63'd0, bif.imem_we}, 64'd1);
    check("exit_core_low", {63'd0, core_resetn}, 64'd0);
`ifndef LOADER_CHECKSUM_EN
    @(negedge clk);
    check("core_rise", {63'd0, core_resetn}, 64'd1);
`else
    send_csum(8'hF3);
`endif
    wait_end();
    check_log();
    check("t1_wc", word_count, 64'd3);
    check("t1_done", {63'd0, load_done}, 64'd1);
    check("t1_core", {63'd0, core_resetn}, 64'd1);
    check("t1_err", {63'd0, load_err}, 64'd0);
    check("t1_done_ready", {63'd0, bif.in_ready}, 64'd0);

    // Same stream with idle gaps between bytes
    clear_log();
    exp_w = '{32'h9000000A, 32'h90010004, 32'hFC000000};
    pulse_start();
    send_word(32'h9000000A, 1);
    send_word(32'h90010004, 2);
    send_word(32'hFC000000, 3);
`ifdef LOADER_CHECKSUM_EN
    send_csum(8'hF3);
`endif
    wait_end();
    check_log();
    check("t2_wc", word_count, 64'd3);
    check("t2_done", {63'd0, load_done}, 64'd1);

    // Sixteen words without EXIT: fill memory, then error
    clear_log();
    for (int i = 0; i < 16; i++) exp_w.push_back(32'h04001000);
    pulse_start();
    for (int i = 0; i < 16; i++) send_word(32'h04001000, 0);
    wait_end();
    check_log();
    check("t3_err", {63'd0, load_err}, 64'd1);
    check("t3_done", {63'd0, load_done}, 64'd0);
    check("t3_core", {63'd0, core_resetn}, 64'd0);
    check("t3_wc", word_count, 64'd16);
    check("t3_addr_hold", bif.imem_addr, 64'd15);
    check("t3_ready", {63'd0, bif.in_ready}, 64'd0);

    // Reset in the middle of word 0 aborts without a write
    clear_log();
    pulse_start();
    send_byte(8'h90, 0);
    send_byte(8'h00, 0);
    resetn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort_we_count", wa.size(), 64'd0);
    check("abort_ready", {63'd0, bif.in_ready}, 64'd0);
    check("abort_addr", bif.imem_addr, 64'd0);
    check("abort_wdata", bif.imem_wdata, 64'd0);
    check("abort_wc", word_count, 64'd0);
    check("abort_core", {63'd0, core_resetn}, 64'd0);
    check("abort_err", {63'd0, load_err}, 64'd0);
    resetn = 1'b1;
    @(negedge clk);
    exp_w = '{32'h9000000A, 32'h90010004, 32'hFC000000};
    pulse_start();
    send_word(32'h9000000A, 0);
    send_word(32'h90010004, 0);
    send_word(32'hFC000000, 0);
`ifdef LOADER_CHECKSUM_EN
    send_csum(8'hF3);
`endif
    wait_end();
    check_log();
    check("t4_wc", word_count, 64'd3);
    check("t4_done", {63'd0, load_done}, 64'd1);

    // Restart from DONE with start and in_valid together: byte not taken
    clear_log();
    exp_w = '{32'hFC000000};
    start        = 1'b1;
    bif.in_valid = 1'b1;
    bif.in_data  = 8'hFC;
    @(negedge clk);
    start = 1'b0;
    check("t5_core_low", {63'd0, core_resetn}, 64'd0);
    check("t5_done_low", {63'd0, load_done}, 64'd0);
    check("t5_wc_clr", word_count, 64'd0);
    check("t5_ready", {63'd0, bif.in_ready}, 64'd1);
    send_word(32'hFC000000, 0);
`ifdef LOADER_CHECKSUM_EN
    send_csum(8'hFC);
`endif
    wait_end();
    check_log();
    check("t5_wc", word_count, 64'd1);
    check("t5_done", {63'd0, load_done}, 64'd1);
    check("t5_core", {63'd0, core_resetn}, 64'd1);

`ifdef LOADER_CHECKSUM_EN
    // Wrong checksum byte ends in ERR; the word stays written
    clear_log();
    exp_w = '{32'hFC000000};
    pulse_start();
    send_word(32'hFC000000, 0);
    send_csum(8'h00);
    wait_end();
    check_log();
    check("t6_err", {63'd0, load_err}, 64'd1);
    check("t6_core", {63'd0, core_resetn}, 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
